lfsr_rr_sched: RTL and testbench

Shared 16-bit pseudo-random word source for the digit-recognition datapath. The block holds one LFSR and hands out one word per cycle to NREQ requesters (weight init, dropout masks, test-pattern generators) under round-robin arbitration. The LFSR advances only when a word is issued, so the issued sequence is deterministic and matches the Matlab golden model for a given seed. Software or the top-level FSM can reseed the block at run time.

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/lfsr_step.sv | 24 ++
 rtl/lfsr_rr_sched.sv | 128 ++++++++++++
 tb/tb_lfsr_rr_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width, feedback taps, scheduler states and the step function.
// The stand-alone lfsr1 datapath uses the same lfsr_next().
package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam int TAP0   = 15;
  localparam int TAP1   = 13;
  localparam int TAP2   = 12;
  localparam int TAP3   = 10;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESEED = 2'd2
  } sched_state_t;

  // x^16+x^14+x^13+x^11+1, Fibonacci form, shifting left.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3]};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// 16-bit LFSR register with load and step enable.
// A zero load value is replaced by 1 so the register can never lock up.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= '0;
    end else if (load) begin
      state <= (load_val == '0) ? LFSR_W'(1) : load_val;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/lfsr_rr_sched.sv
// Shared pseudo-random word source: one LFSR, round-robin issue to NREQ requesters.
// The LFSR steps only on a grant, so the issued sequence depends only on the seed.
//
// state     | meaning
// ST_SEED   | after reset: load DEFAULT_SEED, clear word count
// ST_RUN    | ready, arbitrate and issue at most one word per cycle
// ST_RESEED | seed just loaded from seed_load, no grant this cycle
module lfsr_rr_sched
  import lfsr_pkg::*;
#(
  parameter int          NREQ         = 4,
  parameter logic [15:0] DEFAULT_SEED = 16'h0001,
  localparam int         ID_W         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  input  logic [NREQ-1:0]   req,
  output logic              ready,
  output logic [NREQ-1:0]   gnt,
  output logic              rnd_valid,
  output logic [15:0]       rnd_data,
  output logic [ID_W-1:0]   rnd_id,
  output logic [31:0]       words_issued
);

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   win_idx;
  logic              lfsr_load;
  logic [15:0]       lfsr_load_val;
  logic              do_grant;
  logic              clr_cnt;
  logic [LFSR_W-1:0] lfsr_q;

  lfsr_step u_lfsr (
    .clk      (clk),
    .resetn   (resetn),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .en       (do_grant),
    .state    (lfsr_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_SEED;
    else         state_q <= state_d;
  end

  // A reseed request always beats a grant in the same cycle.
  always_comb begin
    state_d       = state_q;
    lfsr_load     = 1'b0;
    lfsr_load_val = seed;
    do_grant      = 1'b0;
    clr_cnt       = 1'b0;
    case (state_q)
      ST_SEED: begin
        lfsr_load = 1'b1;
        clr_cnt   = 1'b1;
        if (seed_load) begin
          state_d = ST_RESEED;
        end else begin
          lfsr_load_val = DEFAULT_SEED;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
          clr_cnt   = 1'b1;
          state_d   = ST_RESEED;
        end else begin
          do_grant = |req;
        end
      end
      ST_RESEED: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
          clr_cnt   = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_SEED;
    endcase
  end

  always_comb begin
    logic found;
    found   = 1'b0;
    win_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      int idx;
      idx = int'(ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q        <= '0;
      gnt          <= '0;
      rnd_data     <= '0;
      rnd_id       <= '0;
      words_issued <= '0;
    end else begin
      gnt <= '0;
      if (do_grant) begin
        gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
        rnd_data <= lfsr_q;
        rnd_id   <= win_idx;
        ptr_q    <= (win_idx == ID_W'(NREQ-1)) ? '0 : win_idx + ID_W'(1);
      end
      if (clr_cnt)       words_issued <= '0;
      else if (do_grant) words_issued <= words_issued + 32'd1;
    end
  end

  assign ready     = (state_q == ST_RUN);
  assign rnd_valid = |gnt;

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Directed bench for lfsr_rr_sched: sequence, round-robin order, reseed and async reset.
module tb_lfsr_rr_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        seed_load;
  logic [15:0] seed;
  logic [3:0]  req;
  logic        ready;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [15:0] rnd_data;
  logic [1:0]  rnd_id;
  logic [31:0] words_issued;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_tab [12] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020,
                                16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0801};
  logic [15:0] m_lfsr;

  lfsr_rr_sched #(.NREQ(4), .DEFAULT_SEED(16'h0001)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .seed_load    (seed_load),
    .seed         (seed),
    .req          (req),
    .ready        (ready),
    .gnt          (gnt),
    .rnd_valid    (rnd_valid),
    .rnd_data     (rnd_data),
    .rnd_id       (rnd_id),
    .words_issued (words_issued)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mnext(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  initial begin
    resetn = 1'b0; seed_load = 1'b0; seed = 16'h0000; req = 4'b0000;
    repeat (2) tick();
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(rnd_valid), 32'h0);
    chk("rst_data", 32'(rnd_data), 32'h0);
    chk("rst_id", 32'(rnd_id), 32'h0);
    chk("rst_words", words_issued, 32'h0);

    resetn = 1'b1;
    chk("seed_state_ready", 32'(ready), 32'h0);
    tick();
    chk("run_ready", 32'(ready), 32'h1);
    chk("run_idle_valid", 32'(rnd_valid), 32'h0);

    // single requester: seed 1 sequence
    req = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("seq1_gnt", 32'(gnt), 32'h1);
      chk("seq1_data", 32'(rnd_data), 32'(exp_tab[i]));
      chk("seq1_id", 32'(rnd_id), 32'h0);
    end
    req = 4'b0000;
    tick();
    chk("seq1_idle", 32'(rnd_valid), 32'h0);
    chk("seq1_words", words_issued, 32'd12);
    m_lfsr = mnext(16'h0801);

    // move ptr to 2, then req 0011 must wrap to id 0 then id 1
    req = 4'b0010;
    tick();
    chk("ptr_id1", 32'(rnd_id), 32'h1);
    chk("ptr_data1", 32'(rnd_data), 32'(m_lfsr));
    m_lfsr = mnext(m_lfsr);
    req = 4'b0011;
    tick();
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    chk("wrap_data0", 32'(rnd_data), 32'(m_lfsr));
    m_lfsr = mnext(m_lfsr);
    tick();
    chk("wrap_gnt1", 32'(gnt), 32'h2);
    chk("wrap_data1", 32'(rnd_data), 32'(m_lfsr));
    req = 4'b0000;
    chk("wrap_words", words_issued, 32'd15);

    // reseed with 0 while a request is pending
    req = 4'b0001; seed_load = 1'b1; seed = 16'h0000;
    tick();
    seed_load = 1'b0;
    chk("rs0_ready", 32'(ready), 32'h0);
    chk("rs0_nognt", 32'(rnd_valid), 32'h0);
    chk("rs0_words", words_issued, 32'h0);
    tick();
    chk("rs0_ready_back", 32'(ready), 32'h1);
    chk("rs0_nognt2", 32'(rnd_valid), 32'h0);
    tick();
    req = 4'b0000;
    chk("rs0_valid", 32'(rnd_valid), 32'h1);
    chk("rs0_data", 32'(rnd_data), 32'h0001);
    chk("rs0_words1", words_issued, 32'h1);

    // reseed 0xACE1 in the same cycle as a request
    req = 4'b0010; seed_load = 1'b1; seed = 16'hACE1;
    tick();
    seed_load = 1'b0;
    chk("ace_nognt", 32'(rnd_valid), 32'h0);
    tick();
    chk("ace_nognt2", 32'(rnd_valid), 32'h0);
    tick();
    chk("ace_data0", 32'(rnd_data), 32'hACE1);
    chk("ace_id0", 32'(rnd_id), 32'h1);
    chk("ace_words0", words_issued, 32'h1);
    tick();
    req = 4'b0000;
    chk("ace_data1", 32'(rnd_data), 32'h59C3);
    chk("ace_id1", 32'(rnd_id), 32'h1);
    chk("ace_words1", words_issued, 32'h2);

    // back-to-back seed pulses: latest seed wins, RESEED extended
    seed_load = 1'b1; seed = 16'h1111;
    tick();
    seed = 16'hBEEF;
    tick();
    seed_load = 1'b0;
    chk("dbl_ready_low", 32'(ready), 32'h0);
    tick();
    chk("dbl_ready", 32'(ready), 32'h1);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    chk("dbl_data", 32'(rnd_data), 32'hBEEF);

    // async reset mid-stream
    req = 4'b1111;
    tick();
    chk("pre_rst_valid", 32'(rnd_valid), 32'h1);
    resetn = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_valid", 32'(rnd_valid), 32'h0);
    chk("arst_data", 32'(rnd_data), 32'h0);
    chk("arst_id", 32'(rnd_id), 32'h0);
    chk("arst_words", words_issued, 32'h0);
    chk("arst_ready", 32'(ready), 32'h0);
    tick();
    resetn = 1'b1;
    tick();
    chk("post_rst_nognt", 32'(rnd_valid), 32'h0);
    chk("post_rst_ready", 32'(ready), 32'h1);

    // all four requesting: strict rotation, data same as single-requester case
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
      chk("rr_id", 32'(rnd_id), 32'(i % 4));
      chk("rr_data", 32'(rnd_data), 32'(exp_tab[i]));
    end
    req = 4'b0000;
    tick();
    chk("rr_words", words_issued, 32'd8);
    chk("rr_idle", 32'(rnd_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
